// File: rtl/dest_drain_arbiter.sv
// rtl/dest_drain_arbiter.sv - round-robin drain of two destination FIFOs into a 2-entry output buffer
module dest_drain_arbiter #(
    parameter int WORD_SIZE = 6,
    parameter int CNT_W     = 8,
    parameter int DEST_BIT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 d0_empty,
    input  logic                 d1_empty,
    input  logic [WORD_SIZE-1:0] data_d0,
    input  logic [WORD_SIZE-1:0] data_d1,
    input  logic                 out_ready,
    output logic                 pop_D0,
    output logic                 pop_D1,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_dest,
    output logic                 out_valid,
    output logic [CNT_W-1:0]     count_d0,
    output logic [CNT_W-1:0]     count_d1,
    output logic                 dest_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t state, state_nxt;

    // fly_vld/fly_src: a pop issued last cycle whose word is on data_dk now
    logic                      fly_vld;
    logic                      fly_src;
    logic                      last_grant;
    logic [1:0][WORD_SIZE-1:0] buf_data;
    logic [1:0]                buf_dest;
    logic                      rd_ptr;
    logic                      wr_ptr;
    logic [1:0]                buf_cnt;

    logic                      take;
    logic [1:0]                occ_after;
    logic                      credit;
    logic                      elig0;
    logic                      elig1;
    logic                      grant0;
    logic                      grant1;
    logic [WORD_SIZE-1:0]      cap_data;

    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = buf_data[rd_ptr];
    assign out_dest  = buf_dest[rd_ptr];
    assign take      = out_valid && out_ready;
    assign occ_after = buf_cnt - {1'b0, take};
    assign credit    = ({1'b0, occ_after} + {2'b00, fly_vld}) < 3'd2;
    // Empty flags lag a pop by one cycle, so the FIFO just popped sits out a cycle
    assign elig0     = !d0_empty && !(fly_vld && !fly_src);
    assign elig1     = !d1_empty && !(fly_vld && fly_src);
    assign cap_data  = fly_src ? data_d1 : data_d0;
    assign pop_D0    = grant0;
    assign pop_D1    = grant1;
    assign busy      = (state != ST_OFF);

    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            ST_OFF: begin
                if (enable) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) state_nxt = ST_STOP;
                if (credit) begin
                    if (elig0 && elig1) begin
                        grant0 = last_grant;
                        grant1 = !last_grant;
                    end else begin
                        grant0 = elig0;
                        grant1 = elig1;
                    end
                end
            end
            ST_STOP: begin
                if (enable) state_nxt = ST_RUN;
                else if (!fly_vld && buf_cnt == 2'd0) state_nxt = ST_OFF;
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_OFF;
            fly_vld    <= 1'b0;
            fly_src    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state   <= state_nxt;
            fly_vld <= grant0 || grant1;
            fly_src <= grant1;
            if (grant0 || grant1) last_grant <= grant1;
        end
    end

    // Capture and removal may happen in the same cycle; pointers move independently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_data <= '0;
            buf_dest <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            buf_cnt  <= 2'd0;
        end else begin
            if (take) rd_ptr <= ~rd_ptr;
            if (fly_vld) begin
                buf_data[wr_ptr] <= cap_data;
                buf_dest[wr_ptr] <= fly_src;
                wr_ptr           <= ~wr_ptr;
            end
            buf_cnt <= buf_cnt + {1'b0, fly_vld} - {1'b0, take};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_d0 <= '0;
            count_d1 <= '0;
            dest_err <= 1'b0;
        end else if (fly_vld) begin
            if (!fly_src && count_d0 != '1) count_d0 <= count_d0 + 1'b1;
            if (fly_src && count_d1 != '1) count_d1 <= count_d1 + 1'b1;
            if (cap_data[DEST_BIT] != fly_src) dest_err <= 1'b1;
        end
    end

endmodule
